// File: rtl/mem_access_unit_if.sv
// CPU bus seen by the MEM-stage access unit: one request at a time, word-addressed,
// big-endian byte lanes selected by be.
interface mem_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 30
);
   // Handshake: the master drops as_ with addr/rw/wr_data/be valid and holds them
   // stable; the transfer completes on the first rising edge where rdy_ is low
   // (read data sampled then), after which as_ returns high.
   logic [ADDR_W-1:0]   addr;
   logic                as_;
   logic                rw;
   logic [DATA_W-1:0]   wr_data;
   logic [DATA_W/8-1:0] be;
   logic [DATA_W-1:0]   rd_data;
   logic                rdy_;

   modport master (output addr, as_, rw, wr_data, be, input rd_data, rdy_);
   modport slave  (input addr, as_, rw, wr_data, be, output rd_data, rdy_);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: byte/half/word loads and stores over a multi-cycle
// bus with stall request, misalignment detection and bus timeout.
module mem_access_unit #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 30,
   parameter int TIMEOUT    = 255,
   parameter bit SUBWORD_EN = 1'b1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 ex_en,
   input  logic [3:0]                           ex_mem_op,
   input  logic [DATA_W-1:0]                    ex_mem_wr_data,
   input  logic [ADDR_W+$clog2(DATA_W/8)-1:0]   ex_out,
   mem_access_unit_if.master                    bus,
   output logic [DATA_W-1:0]                    out,
   output logic                                 miss_align,
   output logic                                 bus_err,
   output logic                                 busy,
   output logic [1:0]                           dbg_state
);
   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_DONE = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                as_q, as_d;
   logic                rw_q, rw_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]   load_q, load_d;
   logic                err_q, err_d;
   logic                load_op_q, load_op_d;
   logic                sign_q, sign_d;
   logic [1:0]          size_q, size_d;
   logic [OFF_W-1:0]    off_q, off_d;

   // size encoding: 0 byte, 1 halfword, 2 word
   logic                op_mem, op_load, op_sign, aligned, start;
   logic [1:0]          op_size;
   logic [OFF_W-1:0]    off;
   logic [BE_W-1:0]     be_store;
   logic [DATA_W-1:0]   st_data, sh_b, sh_h, ld_ext;

   assign off = ex_out[OFF_W-1:0];

   always_comb begin
      op_mem  = 1'b0;
      op_load = 1'b0;
      op_size = 2'd0;
      case (ex_mem_op)
         4'd1:       begin op_mem = 1'b1;       op_load = 1'b1; op_size = 2'd2; end
         4'd2:       begin op_mem = 1'b1;                       op_size = 2'd2; end
         4'd3, 4'd4: begin op_mem = SUBWORD_EN; op_load = 1'b1; op_size = 2'd1; end
         4'd5:       begin op_mem = SUBWORD_EN;                 op_size = 2'd1; end
         4'd6, 4'd7: begin op_mem = SUBWORD_EN; op_load = 1'b1; op_size = 2'd0; end
         4'd8:       begin op_mem = SUBWORD_EN;                 op_size = 2'd0; end
         default:    ;
      endcase
      op_sign = (ex_mem_op == 4'd3) || (ex_mem_op == 4'd6);
   end

   always_comb begin
      aligned  = 1'b1;
      be_store = '1;
      st_data  = ex_mem_wr_data;
      case (op_size)
         2'd2: aligned = (off == '0);
         2'd1: begin
            aligned  = ~off[0];
            be_store = {2'b11, {(BE_W-2){1'b0}}} >> off;
            st_data  = {(BE_W/2){ex_mem_wr_data[15:0]}};
         end
         default: begin
            be_store = {1'b1, {(BE_W-1){1'b0}}} >> off;
            st_data  = {BE_W{ex_mem_wr_data[7:0]}};
         end
      endcase
   end

   // Offset 0 is the most significant lane, so lanes are right-aligned by shifting down.
   always_comb begin
      sh_b   = bus.rd_data >> (8 * (BE_W - 1 - int'(off_q)));
      sh_h   = bus.rd_data >> (8 * (BE_W - 2 - int'(off_q)));
      ld_ext = bus.rd_data;
      case (size_q)
         2'd0:    ld_ext = {{(DATA_W-8){sign_q & sh_b[7]}}, sh_b[7:0]};
         2'd1:    ld_ext = {{(DATA_W-16){sign_q & sh_h[15]}}, sh_h[15:0]};
         default: ld_ext = bus.rd_data;
      endcase
   end

   assign start = reset & ex_en & op_mem & aligned;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      as_d       = as_q;
      rw_d       = rw_q;
      wr_data_d  = wr_data_q;
      be_d       = be_q;
      cnt_d      = cnt_q;
      load_d     = load_q;
      err_d      = err_q;
      load_op_d  = load_op_q;
      sign_d     = sign_q;
      size_d     = size_q;
      off_d      = off_q;
      busy       = 1'b0;
      out        = '0;
      miss_align = 1'b0;
      bus_err    = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy       = start;
            miss_align = ex_en & op_mem & ~aligned;
            out        = (ex_en & op_mem) ? '0 : DATA_W'(ex_out);
            if (start) begin
               state_d   = S_BUS;
               addr_d    = ex_out[ADDR_W+OFF_W-1:OFF_W];
               as_d      = 1'b0;
               rw_d      = op_load;
               wr_data_d = op_load ? '0 : st_data;
               be_d      = op_load ? '1 : be_store;
               cnt_d     = '0;
               err_d     = 1'b0;
               load_op_d = op_load;
               sign_d    = op_sign;
               size_d    = op_size;
               off_d     = off;
            end
         end
         S_BUS: begin
            busy = 1'b1;
            // Completion is tested first so a ready on the last allowed cycle is not an error.
            if (!bus.rdy_) begin
               as_d    = 1'b1;
               load_d  = ld_ext;
               state_d = S_DONE;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               as_d    = 1'b1;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DONE: begin
            bus_err = err_q;
            out     = (err_q || !load_op_q) ? '0 : load_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         as_q      <= 1'b1;
         rw_q      <= 1'b1;
         wr_data_q <= '0;
         be_q      <= '0;
         cnt_q     <= '0;
         load_q    <= '0;
         err_q     <= 1'b0;
         load_op_q <= 1'b0;
         sign_q    <= 1'b0;
         size_q    <= 2'd0;
         off_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         as_q      <= as_d;
         rw_q      <= rw_d;
         wr_data_q <= wr_data_d;
         be_q      <= be_d;
         cnt_q     <= cnt_d;
         load_q    <= load_d;
         err_q     <= err_d;
         load_op_q <= load_op_d;
         sign_q    <= sign_d;
         size_q    <= size_d;
         off_q     <= off_d;
      end
   end

   assign bus.addr    = addr_q;
   assign bus.as_     = as_q;
   assign bus.rw      = rw_q;
   assign bus.wr_data = wr_data_q;
   assign bus.be      = be_q;
   assign dbg_state   = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a lane-arithmetic
// reference model (32-bit data, TIMEOUT=4).
module tb_mem_access_unit;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_en;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_mem_wr_data;
   logic [31:0] ex_out;
   logic [31:0] out;
   logic        miss_align, bus_err, busy;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   mem_access_unit_if #(.DATA_W(32), .ADDR_W(30)) bus_if ();

   mem_access_unit #(.DATA_W(32), .ADDR_W(30), .TIMEOUT(TO), .SUBWORD_EN(1'b1)) dut (
      .clk            (clk),
      .reset          (reset),
      .ex_en          (ex_en),
      .ex_mem_op      (ex_mem_op),
      .ex_mem_wr_data (ex_mem_wr_data),
      .ex_out         (ex_out),
      .bus            (bus_if),
      .out            (out),
      .miss_align     (miss_align),
      .bus_err        (bus_err),
      .busy           (busy),
      .dbg_state      (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference model: access size in bytes, lane arithmetic on byte offsets.
   function automatic bit m_is_mem(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd8);
   endfunction

   function automatic int m_size(input logic [3:0] op);
      if (op == 4'd1 || op == 4'd2) return 4;
      if (op >= 4'd3 && op <= 4'd5) return 2;
      return 1;
   endfunction

   function automatic bit m_is_load(input logic [3:0] op);
      return op inside {4'd1, 4'd3, 4'd4, 4'd6, 4'd7};
   endfunction

   function automatic logic [31:0] m_load(input logic [3:0] op, input int off, input logic [31:0] rd);
      int sz = m_size(op);
      logic [31:0] v;
      v = rd >> (8 * (4 - sz - off));
      if (sz == 1) v = v & 32'h0000_00FF;
      if (sz == 2) v = v & 32'h0000_FFFF;
      if (op == 4'd6 && v[7])  v = v | 32'hFFFF_FF00;
      if (op == 4'd3 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   function automatic logic [3:0] m_be(input logic [3:0] op, input int off);
      logic [3:0] b = 4'h0;
      if (m_is_load(op)) return 4'hF;
      for (int k = off; k < off + m_size(op); k++) b[3-k] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] w);
      case (m_size(op))
         4:       return w;
         2:       return (w & 32'h0000_FFFF) * 32'h0001_0001;
         default: return (w & 32'h0000_00FF) * 32'h0101_0101;
      endcase
   endfunction

   // Called just after a rising edge with the unit idle; returns just after a rising edge, idle.
   task automatic run_op(input logic [3:0] op, input logic [31:0] baddr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int wait_n, input bit flush);
      int off = int'(baddr[1:0]);
      bit timeout = (wait_n >= TO);
      ex_en = 1'b1; ex_mem_op = op; ex_out = baddr; ex_mem_wr_data = wdata;
      bus_if.rdy_ = 1'b1; bus_if.rd_data = rdata;
      #1;
      if (!m_is_mem(op)) begin
         check("pass_out", out, baddr);
         check("pass_busy", busy, 0);
         check("pass_ma", miss_align, 0);
         @(posedge clk); #1;
         check("pass_as", bus_if.as_, 1);
         return;
      end
      if ((off % m_size(op)) != 0) begin
         check("mis_flag", miss_align, 1);
         check("mis_out", out, 0);
         check("mis_busy", busy, 0);
         @(posedge clk); #1;
         check("mis_as", bus_if.as_, 1);
         ex_en = 1'b0;
         return;
      end
      check("start_busy", busy, 1);
      check("start_ma", miss_align, 0);
      exp_q.push_back(timeout ? 32'h0 : (m_is_load(op) ? m_load(op, off, rdata) : 32'h0));
      @(posedge clk); #1;
      for (int n = 0; n < TO; n++) begin
         check("bus_as", bus_if.as_, 0);
         check("bus_busy", busy, 1);
         check("bus_addr", bus_if.addr, {2'b00, baddr[31:2]});
         if (n == 0) begin
            check("bus_be", bus_if.be, m_be(op, off));
            check("bus_rw", bus_if.rw, m_is_load(op));
            if (!m_is_load(op)) check("bus_wdata", bus_if.wr_data, m_wdata(op, wdata));
         end
         if (flush) ex_en = 1'b0;
         bus_if.rdy_ = (n == wait_n) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         if (n == wait_n || n == TO - 1) break;
      end
      check("done_out", out, exp_q.pop_front());
      check("done_err", bus_err, timeout);
      check("done_busy", busy, 0);
      check("done_as", bus_if.as_, 1);
      bus_if.rdy_ = 1'b1; ex_en = 1'b0; ex_mem_op = 4'd0;
      @(posedge clk); #1;
      check("idle_err", bus_err, 0);
      check("idle_as", bus_if.as_, 1);
   endtask

   initial begin
      logic [31:0] ra, rw_, rd;
      reset = 1'b0; ex_en = 1'b0; ex_mem_op = 4'd0; ex_mem_wr_data = '0; ex_out = '0;
      bus_if.rdy_ = 1'b1; bus_if.rd_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_as", bus_if.as_, 1);
      check("rst_rw", bus_if.rw, 1);
      check("rst_addr", bus_if.addr, 0);
      check("rst_wdata", bus_if.wr_data, 0);
      check("rst_be", bus_if.be, 0);
      check("rst_busy", busy, 0);
      check("rst_err", bus_err, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      run_op(4'd1, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 1'b0);
      run_op(4'd6, 32'h0000_0103, 32'h0, 32'h0000_00F0, 1, 1'b0);
      run_op(4'd7, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 1'b0);
      run_op(4'd5, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 0, 1'b0);
      run_op(4'd8, 32'h0000_0101, 32'h0000_005A, 32'h0, 2, 1'b0);
      run_op(4'd1, 32'h0000_0102, 32'h0, 32'h0, 0, 1'b0);
      run_op(4'd3, 32'h0000_0101, 32'h0, 32'h0, 0, 1'b0);
      run_op(4'd3, 32'h0000_0200, 32'h0, 32'h8001_7FFF, 0, 1'b0);
      run_op(4'd4, 32'h0000_0202, 32'h0, 32'h8001_8FFF, 0, 1'b0);
      run_op(4'd1, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 99, 1'b0);
      run_op(4'd2, 32'h0000_0304, 32'h1111_2222, 32'h0, 99, 1'b0);
      run_op(4'd1, 32'h0000_0308, 32'h0, 32'hA5A5_5A5A, TO - 1, 1'b0);
      run_op(4'd7, 32'h0000_0401, 32'h0, 32'h0011_2233, 1, 1'b1);
      run_op(4'd12, 32'h0000_0555, 32'h0, 32'h0, 0, 1'b0);

      // Reset mid-access abandons the transfer immediately.
      ex_en = 1'b1; ex_mem_op = 4'd1; ex_out = 32'h0000_0600; bus_if.rdy_ = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_as_before", bus_if.as_, 0);
      #2 reset = 1'b0;
      #1;
      check("rst_mid_as", bus_if.as_, 1);
      check("rst_mid_busy", busy, 0);
      ex_en = 1'b0; ex_mem_op = 4'd0;
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_idle_as", bus_if.as_, 1);
      run_op(4'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom; rw_ = $urandom; rd = $urandom;
         run_op(4'($urandom_range(0, 15)), ra, rw_, rd, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
